bus_rd_fifo: RTL

BUS_RD_FIFO -- requirements
Module: bus_rd_fifo

---
 rtl/bus_rd_fifo_pkg.sv | 13 +
 rtl/bus_rd_fifo_mem.sv | 26 ++
 rtl/bus_rd_fifo.sv | 115 +++++++++++
 3 files changed

// File: rtl/bus_rd_fifo_pkg.sv
// Shared bus read-FIFO definitions.
// Default geometry and a small helper used by the FIFO top.
package bus_rd_fifo_pkg;

    localparam int BRF_DATAWIDTH  = 16;
    localparam int BRF_DEPTH_LOG2 = 4;

    // Entry count for a given pointer width
    function automatic int brf_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/bus_rd_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the top masks them while empty.
module bus_rd_fifo_mem #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [(1<<AW)];

    // Write the accepted entry at the write pointer
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_rd_fifo.sv
// Read FIFO feeding a read-only bus register ({not_empty, head}).
// Optional sticky overflow flag: define BUS_RD_FIFO_OVF_EN.
module bus_rd_fifo
    import bus_rd_fifo_pkg::*;
#(
    parameter int DATAWIDTH  = BRF_DATAWIDTH,
    parameter int DEPTH_LOG2 = BRF_DEPTH_LOG2
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset,
    input  logic                  push,
    input  logic [DATAWIDTH-1:0]  push_data,
    input  logic                  rd_pulse,
    input  logic                  clr,
    output logic [DATAWIDTH:0]    out,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  ovf
);

    localparam logic [DEPTH_LOG2:0]   L_DEPTH   = brf_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   L_CNT_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = 1;

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_drop;
    logic [DATAWIDTH-1:0]  w_rd_data;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == L_DEPTH);
    // A pop on an empty FIFO is ignored; a push on a full FIFO is
    // only taken when a pop frees the head slot in the same cycle.
    assign w_pop_ok  = rd_pulse && !w_empty;
    assign w_push_ok = push && (!w_full || w_pop_ok);
    assign w_drop    = push && w_full && !w_pop_ok;

    // Net occupancy change for this edge
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + L_CNT_ONE;
            2'b01:   w_count_nxt = r_count - L_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers and count; clr overrides push and pop
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

`ifdef BUS_RD_FIFO_OVF_EN
    logic r_ovf;

    // Sticky flag raised when a push is dropped
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
    assign ovf           = 1'b0;
`endif

    bus_rd_fifo_mem #(
        .DW (DATAWIDTH),
        .AW (DEPTH_LOG2)
    ) u_mem (
        .i_clk   (bus_clk),
        .i_we    (w_push_ok && !clr),
        .i_waddr (r_wr_ptr),
        .i_wdata (push_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    // Outputs depend on registered state only, so they hold steady
    // for the whole cycle a bus read samples them.
    assign out   = w_empty ? '0 : {1'b1, w_rd_data};
    assign count = r_count;
    assign full  = w_full;

endmodule
